// File: rtl/multi_ch_timer.sv
// Multi-channel down-counting timer with a shared prescaler.
// Each channel is one-shot or periodic, with a tick pulse and a sticky irq.
module multi_ch_timer #(
    parameter int N_CH        = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [PRESC_WIDTH-1:0]    presc_i,
    input  logic                      wr_en_i,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch_i,
    input  logic [CNT_WIDTH-1:0]      wr_data_i,
    input  logic [N_CH-1:0]           start_i,
    input  logic [N_CH-1:0]           stop_i,
    input  logic [N_CH-1:0]           mode_i,
    input  logic [N_CH-1:0]           irq_clr_i,
    output logic [N_CH-1:0]           busy_o,
    output logic [N_CH-1:0]           tick_o,
    output logic [N_CH-1:0]           irq_o,
    output logic [N_CH*CNT_WIDTH-1:0] cnt_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    logic [PRESC_WIDTH-1:0] presc_cnt_q;
    logic [PRESC_WIDTH-1:0] presc_cnt_d;
    logic                   strobe;

    // >= rather than == so a lowered divide value never forces a full wrap
    assign strobe      = (presc_cnt_q >= presc_i);
    assign presc_cnt_d = strobe ? '0 : presc_cnt_q + PRESC_WIDTH'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [CNT_WIDTH-1:0] reload_q, reload_d;
        logic                 mode_q, mode_d;
        logic                 tick_q, tick_d;
        logic                 irq_q, irq_d;
        logic                 wr_sel;

        assign wr_sel = wr_en_i && (wr_ch_i == CH_W'(k));

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            mode_d   = mode_q;
            tick_d   = 1'b0;
            reload_d = wr_sel ? wr_data_i : reload_q;
            irq_d    = tick_q | (irq_q & ~irq_clr_i[k]);
            // stop beats start and expiry; start loads the pre-write reload
            if (stop_i[k]) begin
                state_d = IDLE;
            end else if (start_i[k]) begin
                state_d = RUN;
                cnt_d   = reload_q;
                mode_d  = mode_i[k];
            end else if (state_q == RUN && strobe) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else begin
                    tick_d = 1'b1;
                    if (mode_q) begin
                        cnt_d = reload_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                reload_q <= '0;
                mode_q   <= 1'b0;
                tick_q   <= 1'b0;
                irq_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                reload_q <= reload_d;
                mode_q   <= mode_d;
                tick_q   <= tick_d;
                irq_q    <= irq_d;
            end
        end

        assign busy_o[k] = (state_q == RUN);
        assign tick_o[k] = tick_q;
        assign irq_o[k]  = irq_q;
        assign cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

endmodule

// File: tb/tb_multi_ch_timer.sv
// Bench for multi_ch_timer: expected ticks queued by stimulus,
// checked by a negedge monitor; state checks use hand-computed values.
module tb_multi_ch_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  presc = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  start = '0;
    logic [2:0]  stop = '0;
    logic [2:0]  mode = '0;
    logic [2:0]  irq_clr = '0;
    logic [2:0]  busy_o;
    logic [2:0]  tick_o;
    logic [2:0]  irq_o;
    logic [23:0] cnt_o;

    multi_ch_timer #(
        .N_CH(3),
        .CNT_WIDTH(8),
        .PRESC_WIDTH(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .presc_i(presc),
        .wr_en_i(wr_en),
        .wr_ch_i(wr_ch),
        .wr_data_i(wr_data),
        .start_i(start),
        .stop_i(stop),
        .mode_i(mode),
        .irq_clr_i(irq_clr),
        .busy_o(busy_o),
        .tick_o(tick_o),
        .irq_o(irq_o),
        .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    // edge index since reset release: edge n is the n-th rising edge
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int ch, input int c);
        exp_t e;
        e.ch  = ch;
        e.cyc = c;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] cnt(input int k);
        return cnt_o[k*8 +: 8];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (tick_o[k]) begin
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_tick: ch %0d at edge %0d, none expected", k, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("tick {ch,edge}", {32'(k), 32'(cyc)},
                            {32'(e.ch), 32'(e.cyc)});
                    end
                end
            end
        end
    end

    task automatic to_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {wr_en, start, stop, mode, irq_clr} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_data = 8'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy_o), 0);
        chk("rst tick", 64'(tick_o), 0);
        chk("rst irq", 64'(irq_o), 0);
        chk("rst cnt", 64'(cnt_o), 0);

        // periodic ch0, presc 0, reload 3 -> tick every 4 clocks
        do_reset();
        presc = 8'd0;
        wr(0, 3);
        to_cyc(1);
        wr_en = 1'b0;
        start = 3'b001;
        mode  = 3'b001;
        push(0, 6);
        push(0, 10);
        push(0, 14);
        to_cyc(2);
        start = '0;
        chk("t1 busy0", 64'(busy_o[0]), 1);
        chk("t1 cnt0", 64'(cnt(0)), 3);
        to_cyc(14);
        chk("t1 busy0 run", 64'(busy_o[0]), 1);
        stop = 3'b001;
        to_cyc(15);
        stop = '0;
        chk("t1 busy0 stop", 64'(busy_o[0]), 0);
        chk("t1 cnt0 held", 64'(cnt(0)), 3);
        chk("t1 irq0", 64'(irq_o[0]), 1);
        chk("t1 sb empty", 64'(sb.size()), 0);

        // one-shot ch1, presc 2, reload 1, start on a strobe edge
        do_reset();
        presc = 8'd2;
        wr(1, 1);
        to_cyc(1);
        wr_en = 1'b0;
        to_cyc(2);
        start = 3'b010;
        mode  = 3'b000;
        push(1, 9);
        to_cyc(3);
        start = '0;
        to_cyc(8);
        chk("t2 busy1 run", 64'(busy_o[1]), 1);
        to_cyc(11);
        chk("t2 busy1 done", 64'(busy_o[1]), 0);
        chk("t2 cnt1", 64'(cnt(1)), 0);
        chk("t2 irq1", 64'(irq_o[1]), 1);

        // start and stop together on ch2: stays idle
        wr(2, 5);
        to_cyc(12);
        wr_en = 1'b0;
        start = 3'b100;
        stop  = 3'b100;
        to_cyc(13);
        start = '0;
        stop  = '0;
        to_cyc(25);
        chk("t3 busy2", 64'(busy_o[2]), 0);
        chk("t3 cnt2", 64'(cnt(2)), 0);
        chk("t3 sb empty", 64'(sb.size()), 0);

        // mid-count reload write on ch0; ch1 expires alongside it
        do_reset();
        presc = 8'd0;
        wr(0, 5);
        to_cyc(1);
        wr(1, 2);
        to_cyc(2);
        wr_en = 1'b0;
        start = 3'b011;
        mode  = 3'b011;
        push(1, 6);
        push(0, 9);
        push(1, 9);
        push(0, 12);
        push(1, 12);
        push(0, 15);
        push(1, 15);
        to_cyc(3);
        start = '0;
        to_cyc(4);
        wr(0, 2);
        to_cyc(5);
        wr_en = 1'b0;
        chk("t4 cnt0 unaltered", 64'(cnt(0)), 3);
        to_cyc(15);
        stop = 3'b011;
        to_cyc(16);
        stop = '0;
        chk("t4 busy", 64'(busy_o), 0);
        chk("t4 sb empty", 64'(sb.size()), 0);

        // irq clear vs set, then async reset mid-count
        do_reset();
        presc = 8'd0;
        wr(0, 1);
        to_cyc(1);
        wr(1, 20);
        to_cyc(2);
        wr(2, 30);
        to_cyc(3);
        wr_en = 1'b0;
        start = 3'b111;
        mode  = 3'b001;
        push(0, 6);
        push(0, 8);
        to_cyc(4);
        start = '0;
        to_cyc(6);
        irq_clr = 3'b001;
        to_cyc(7);
        chk("t5 irq0 set wins", 64'(irq_o[0]), 1);
        to_cyc(8);
        irq_clr = '0;
        chk("t5 irq0 cleared", 64'(irq_o[0]), 0);
        to_cyc(9);
        chk("t5 busy pre-rst", 64'(busy_o), 7);
        #1;
        rst = 1'b1;
        #1;
        chk("t5 rst busy", 64'(busy_o), 0);
        chk("t5 rst tick", 64'(tick_o), 0);
        chk("t5 rst irq", 64'(irq_o), 0);
        chk("t5 rst cnt", 64'(cnt_o), 0);
        @(negedge clk);
        rst = 1'b0;
        to_cyc(40);
        chk("t5 busy after", 64'(busy_o), 0);
        chk("t5 sb empty", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_ch_timer.md
MULTI_CH_TIMER -- requirements
Module: multi_ch_timer

Interface
REQ-001 The module SHALL have parameter N_CH, default 4: number of independent timer channels, range 1..16.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8: width of each channel counter and reload value.
REQ-003 The module SHALL have parameter PRESC_WIDTH, default 8: width of the shared prescaler.
REQ-004 The module SHALL have local parameter CH_W = max(1, clog2(N_CH)).
REQ-005 clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 rst_i  input  1  reset; asynchronous, active-high.
REQ-007 presc_i  input  PRESC_WIDTH  prescaler divide value; strobe period = presc_i+1 clocks.
REQ-008 wr_en_i  input  1  reload-register write strobe.
REQ-009 wr_ch_i  input  CH_W  channel selected by the write.
REQ-010 wr_data_i  input  CNT_WIDTH  reload value written.
REQ-011 start_i  input  N_CH  per-channel start pulse.
REQ-012 stop_i  input  N_CH  per-channel stop pulse.
REQ-013 mode_i  input  N_CH  per-channel mode, sampled at start: 0 = one-shot, 1 = periodic.
REQ-014 irq_clr_i  input  N_CH  per-channel clear for irq_o.
REQ-015 busy_o  output  N_CH  channel is in RUN.
REQ-016 tick_o  output  N_CH  one-cycle expiry pulse.
REQ-017 irq_o  output  N_CH  sticky expiry flag.
REQ-018 cnt_o  output  N_CH*CNT_WIDTH  current counters; channel k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-019 The prescaler counter SHALL free-run: strobe=1 in a cycle when presc_cnt >= presc_i, and presc_cnt <= 0 in that cycle, else presc_cnt <= presc_cnt+1.
- Comparison is >=, so lowering presc_i never causes a wrap.
REQ-020 With presc_i=0, strobe SHALL be 1 every cycle.
REQ-021 Each channel SHALL hold a registered reload value, mode bit and counter, and run a two-state FSM: IDLE and RUN.
REQ-022 When wr_en_i=1 and wr_ch_i<N_CH, reload[wr_ch_i] <= wr_data_i; wr_ch_i>=N_CH SHALL be ignored.
REQ-023 A write SHALL NOT alter a running counter; the new value applies at the next start or periodic reload.
REQ-024 When start_i[k]=1 in either state, the channel SHALL load cnt <= reload[k] and latch mode_i[k] into mode[k].
- Uses the reload value before any same-cycle write.
- Channel is RUN from the next cycle; start while RUN restarts it.
REQ-025 When stop_i[k]=1, the channel SHALL enter IDLE with cnt held, and no tick SHALL be issued that cycle.
- stop_i wins over a simultaneous start_i and over a simultaneous expiry.
REQ-026 In RUN with strobe=1 and cnt>0, cnt SHALL decrement by 1.
REQ-027 In RUN with strobe=1 and cnt=0 (expiry):
- tick_o[k] SHALL be 1 in the following cycle only.
- mode[k]=1 (periodic): cnt <= reload[k], channel stays RUN.
- mode[k]=0 (one-shot): channel enters IDLE, cnt stays 0.
REQ-028 Expiry period SHALL be (reload+1)*(presc_i+1) clocks; reload=0 gives a tick on every strobe.
REQ-029 A start coinciding with a strobe SHALL only load; decrementing begins at the next strobe.
REQ-030 irq_o[k] SHALL set on tick_o[k] and clear on irq_clr_i[k]; a simultaneous set and clear SHALL leave irq_o[k]=1.
REQ-031 busy_o[k] SHALL be 1 exactly when channel k is in RUN; all outputs SHALL be registered.
REQ-032 Channels SHALL be fully independent; simultaneous expiries on several channels SHALL all tick in the same cycle.

Reset
REQ-033 While rst_i=1 (asynchronously asserted):
- every FSM SHALL be IDLE.
- presc_cnt, reload, mode and cnt SHALL be 0.
- busy_o, tick_o and irq_o SHALL be 0.
REQ-034 Reset asserted mid-count SHALL abort all channels with no tick.
REQ-035 After reset release, no channel SHALL run until started.

Verification
REQ-036 presc_i=0; write reload[0]=3; start_i[0], mode=1 -> tick_o[0] pulses every 4 clocks; busy_o[0] stays 1.
REQ-037 presc_i=2; reload[1]=1; mode=0; start ch1 -> single tick_o[1] 6 clocks after start, then busy_o[1]=0 and cnt=0.
REQ-038 Assert start_i[2] and stop_i[2] in the same cycle -> ch2 stays IDLE; no tick.
REQ-039 Periodic ch0 with reload=5; write 2 mid-count -> current period completes at 6 strobes; later periods are 3 strobes.
REQ-040 Assert irq_clr_i[0] in the same cycle as tick_o[0] -> irq_o[0]=1; clear alone one cycle later -> irq_o[0]=0.
REQ-041 Assert rst_i mid-count on all channels -> all outputs 0 immediately (asynchronously); no tick after release.
